fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Single-clock, parametrised FIFO; next generation of the team's fifo block.
//  Adds selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty
//  thresholds, an occupancy count and sticky overflow/underflow error flags.
//  Sits behind fifo_wrapper as the buffering core between producer and consumer logic.
// PARAMETERS
//  DATA_W    8   width of each stored word
//  DEPTH     16  number of entries; power of 2, >= 4
//  FWFT      0   0 = standard (registered read), 1 = first-word-fall-through
//  AF_LEVEL  12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  4   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1                    single clock, rising edge
//  rst           in   1                    synchronous, active-high reset
//  push          in   1                    write request
//  data_in       in   DATA_W               write data, sampled with push
//  pop           in   1                    read request
//  data_out      out  DATA_W               read data
//  full          out  1                    count == DEPTH
//  empty         out  1                    count == 0
//  almost_full   out  1                    count >= AF_LEVEL
//  almost_empty  out  1                    count <= AE_LEVEL
//  count         out  $clog2(DEPTH+1)      current occupancy
//  overflow      out  1                    sticky: push rejected because FIFO was full
//  underflow     out  1                    sticky: pop while empty
//  clr_err       in   1                    clears overflow/underflow
// BEHAVIOUR
//  - Reset (sync, active-high): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0,
//    almost_empty = 1, almost_full = 0, overflow = underflow = 0, data_out = 0.
//    Memory contents are not cleared. Reset mid-operation discards all stored words.
//  - Pointers are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
//    Address wraps from DEPTH-1 to 0.
//  - pop_ok  = pop & ~empty
//  - push_ok = push & (~full | pop_ok): push into a full FIFO succeeds only with a same-cycle valid pop.
//  - Push and pop together with 0 < count < DEPTH: both accepted, count unchanged.
//  - Push and pop together when empty: push accepted, pop rejected, underflow set.
//  - count_next = count + push_ok - pop_ok. All status flags are registered from count_next,
//    so they update on the edge where the push or pop is accepted.
//  - FWFT=0: data_out <= mem[rd_ptr] on the edge of an accepted pop (1-cycle latency).
//    data_out holds its value otherwise.
//  - FWFT=1: data_out always presents the head word while ~empty. A pushed word is visible the
//    cycle after push into an empty FIFO. pop_ok advances to the next word the following cycle.
//    data_out is don't-care while empty and must not be X after reset (reads 0).
//  - overflow <= 1 on push & ~push_ok. underflow <= 1 on pop & empty.
//    clr_err clears both; a set event in the same cycle as clr_err wins.
//    Rejected operations change neither pointers nor memory.
// STRUCTURE
//  - Package fifo_pkg: data_t (logic [DATA_W-1:0]), default DEPTH/DATA_W constants,
//    and the fifo_mode_e enum {FIFO_STD, FIFO_FWFT}.
//  - Sub-module fifo_mem: simple dual-port RAM, DEPTH x DATA_W, synchronous write,
//    read port async (FWFT) or registered (STD).
//  - The top level holds pointers, count, flag and error logic, plus the FWFT output mux.
// TESTING (DEPTH=16, DATA_W=8, AF=12, AE=4)
//  1 Fill/drain: push 0x00..0x0F, then 16 pops -> data_out 0x00..0x0F in order.
//    full=1 after the 16th push, empty=1 after the 16th pop. Run with FWFT=0 and FWFT=1.
//  2 Overflow: 16 pushes, then push 0xAA -> overflow=1, count stays 16.
//    Drain -> 0x00..0x0F; 0xAA is never seen. clr_err -> overflow=0.
//  3 Underflow: pop on an empty FIFO after reset -> underflow=1, count=0, empty=1.
//    Push 0x55 and clr_err in the same cycle -> underflow=0, data 0x55 readable.
//  4 Thresholds: pushes 1..16 -> almost_empty drops at count 5, almost_full rises at count 12.
//    Pops reverse both at the same counts.
//  5 Simultaneous: at count 16, push 0x77 + pop -> no overflow, count stays 16, 0x77 is read last.
//    At count 0, push + pop -> count=1, underflow=1.
//  6 Reset mid-stream: after 9 pushes, assert rst for 1 cycle -> count=0, empty=1, flags at reset values.
//    Next push 0x3C is the next word read.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    typedef logic [DEFAULT_DATA_W-1:0] data_t;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, read port asynchronous (FWFT) or registered (STD).
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int         DATA_W = DEFAULT_DATA_W,
    parameter int         DEPTH  = DEFAULT_DEPTH,
    parameter fifo_mode_e MODE   = FIFO_STD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset on purpose; clearing it would block RAM
    // inference and nothing downstream ever reads an unwritten entry as valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_async_rd
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = rst ^ rd_en_i;
            assign rd_data_o      = mem_q[rd_addr_i];
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rd_data_q;
            // Only the output register is reset so data_out reads 0 after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_en_i) begin
                    rd_data_q <= mem_q[rd_addr_i];
                end
            end
            assign rd_data_o = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with optional FWFT output, thresholds, occupancy and sticky errors.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int         AW   = $clog2(DEPTH);
    localparam int         PW   = AW + 1;
    localparam int         CW   = $clog2(DEPTH + 1);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic              pop_ok;
    logic              push_ok;
    logic [DATA_W-1:0] rd_data;

    // A full FIFO still accepts a push when a valid pop frees a slot on the same edge.
    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // A set event outranks clr_err in the same cycle.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (push & ~push_ok) ovf_d = 1'b1;
        if (pop & empty_q)   unf_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MODE   (MODE)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (pop_ok),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    // In FWFT mode the head word is masked while empty so data_out never shows stale or unwritten RAM.
    assign data_out     = (MODE == FIFO_FWFT && empty_q) ? '0 : rd_data;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard and an FWFT instance in lockstep against a queue-based reference model.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic  clk = 1'b0;
    logic  rst, push, pop, clr_err;
    data_t data_in;

    data_t      s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int errors = 0;
    int checks = 0;

    data_t mq[$];
    data_t m_std_dout;
    bit    m_ovf, m_unf;
    bit    model_on = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop), .data_out(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop), .data_out(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded queue with sticky error bits.
    task automatic model_update();
        int n;
        bit pop_ok, push_ok;
        if (rst) begin
            mq.delete();
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_std_dout = '0;
            model_on   = 1'b1;
        end else begin
            n       = mq.size();
            pop_ok  = pop && (n > 0);
            push_ok = push && ((n < DEPTH) || pop_ok);
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && n == 0)    m_unf = 1'b1;
            if (pop_ok)  m_std_dout = mq.pop_front();
            if (push_ok) mq.push_back(data_in);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("s_count", s_count, mq.size());
            check("f_count", f_count, mq.size());
            check("s_full",  s_full,  mq.size() == DEPTH);
            check("f_full",  f_full,  mq.size() == DEPTH);
            check("s_empty", s_empty, mq.size() == 0);
            check("f_empty", f_empty, mq.size() == 0);
            check("s_af",    s_af,    mq.size() >= AF);
            check("f_af",    f_af,    mq.size() >= AF);
            check("s_ae",    s_ae,    mq.size() <= AE);
            check("f_ae",    f_ae,    mq.size() <= AE);
            check("s_ovf",   s_ovf,   m_ovf);
            check("f_ovf",   f_ovf,   m_ovf);
            check("s_unf",   s_unf,   m_unf);
            check("f_unf",   f_unf,   m_unf);
            check("s_dout",  s_dout,  m_std_dout);
            if (mq.size() > 0) check("f_dout", f_dout, mq[0]);
        end
    end

    task automatic cyc(input bit p, input data_t d, input bit q, input bit c, input bit r);
        push    = p;
        data_in = d;
        pop     = q;
        clr_err = c;
        rst     = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(0, 8'h00, 0, 0, 1);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cyc(1, 8'(i), 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        @(negedge clk);
        do_reset();
        do_reset();

        // Reset state, pinned with literals.
        check("rst_count", s_count, 0);
        check("rst_empty", s_empty, 1);
        check("rst_full",  s_full,  0);
        check("rst_ae",    s_ae,    1);
        check("rst_af",    s_af,    0);
        check("rst_ovf",   s_ovf,   0);
        check("rst_unf",   s_unf,   0);
        check("rst_sdout", s_dout,  0);
        check("rst_fdout", f_dout,  0);

        // Fill/drain with threshold crossings.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            check("fill_count", s_count, i + 1);
            check("fill_ae", s_ae, (i + 1) <= 4);
            check("fill_af", f_af, (i + 1) >= 12);
        end
        check("fill_full", s_full, 1);
        for (int i = 0; i < 16; i++) begin
            check("fwft_head", f_dout, i);
            cyc(0, 8'h00, 1, 0, 0);
            check("drain_data", s_dout, i);
            check("drain_ae", f_ae, (15 - i) <= 4);
            check("drain_af", s_af, (15 - i) >= 12);
        end
        check("drain_empty", s_empty, 1);

        // Overflow is sticky, rejected word never stored.
        fill(16);
        cyc(1, 8'hAA, 0, 0, 0);
        check("ovf_set", s_ovf, 1);
        check("ovf_count", f_count, 16);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0, 0);
            check("ovf_drain", s_dout, i);
        end
        cyc(0, 8'h00, 0, 1, 0);
        check("ovf_clr", s_ovf, 0);

        // Underflow, then clear in the same cycle as a push.
        do_reset();
        cyc(0, 8'h00, 1, 0, 0);
        check("unf_set", s_unf, 1);
        check("unf_count", s_count, 0);
        check("unf_empty", f_empty, 1);
        cyc(1, 8'h55, 0, 1, 0);
        check("unf_clr", f_unf, 0);
        check("fwft_55", f_dout, 8'h55);
        cyc(0, 8'h00, 1, 0, 0);
        check("std_55", s_dout, 8'h55);

        // Simultaneous push/pop at full and at empty.
        fill(16);
        cyc(1, 8'h77, 1, 0, 0);
        check("sim_full_ovf", s_ovf, 0);
        check("sim_full_count", s_count, 16);
        check("sim_full_dout", s_dout, 8'h00);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 0);
        check("sim_last", s_dout, 8'h77);
        cyc(1, 8'h12, 1, 0, 0);
        check("sim_empty_count", s_count, 1);
        check("sim_empty_unf", s_unf, 1);
        cyc(0, 8'h00, 1, 1, 0);

        // Reset mid-stream discards stored words.
        fill(9);
        do_reset();
        check("mid_rst_count", s_count, 0);
        check("mid_rst_empty", f_empty, 1);
        check("mid_rst_ae", s_ae, 1);
        check("mid_rst_af", s_af, 0);
        cyc(1, 8'h3C, 0, 0, 0);
        check("mid_rst_fwft", f_dout, 8'h3C);
        cyc(0, 8'h00, 1, 0, 0);
        check("mid_rst_std", s_dout, 8'h3C);

        // Random traffic alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int pp, qp;
            pp = ((i / 80) % 2 == 0) ? 80 : 30;
            qp = ((i / 80) % 2 == 0) ? 30 : 80;
            cyc($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 99) < qp,
                $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
